// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR scheduler.
// Latency: n/a (types, constants and a pure step function).
// Backpressure: n/a.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } lfsr_sched_state_t;

    // Polynomial x^16+x^14+x^13+x^11+1 in right-shift Galois form.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;

    // Zero-extended operands let callers of any width up to 32 share one step function.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        return (state >> 1) ^ (state[0] ? taps : 32'd0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, circularly.
// Latency: combinational.
// Backpressure: none; requests that lose simply stay asserted.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDW = $clog2(NREQ);

    always_comb begin
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/lfsr_sched.sv
// Shared Galois LFSR handed out to NREQ requesters by round-robin grant, with period measurement.
// Latency: req sampled at one edge, gnt/rnd_* registered after that same edge for one cycle.
// Backpressure: enable=0 or seed_load stalls grants; requesters hold req until granted.
module lfsr_sched
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               NREQ         = 4,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(LFSR_TAPS),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seed_load,
    input  logic [WIDTH-1:0]        seed_in,
    input  logic                    enable,
    input  logic                    free_run,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    rnd_valid,
    output logic [WIDTH-1:0]        rnd_data,
    output logic [$clog2(NREQ)-1:0] rnd_id,
    output logic                    period_done,
    output logic [WIDTH:0]          period_cnt,
    output logic                    busy
);

    localparam int             IDW     = $clog2(NREQ);
    localparam logic [WIDTH:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};

    lfsr_sched_state_t state;
    logic [WIDTH-1:0]  lfsr;
    logic [WIDTH-1:0]  ref_seed;
    logic [IDW-1:0]    rr_ptr;
    logic [WIDTH:0]    adv_cnt;

    logic [WIDTH-1:0]  nxt;
    logic [WIDTH-1:0]  seed_clean;
    logic              win_any;
    logic [NREQ-1:0]   win_onehot;
    logic [IDW-1:0]    win_idx;
    logic              grant_go;
    logic              advance;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .any    (win_any),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    assign nxt        = WIDTH'(lfsr_next(32'(lfsr), 32'(TAPS)));
    assign seed_clean = (seed_in == '0) ? DEFAULT_SEED : seed_in;

    // A seed load pre-empts any grant or advance in the same cycle.
    assign grant_go = (state == RUN) && !seed_load && enable && win_any;
    assign advance  = (state == RUN) && !seed_load && enable && (win_any || free_run);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            lfsr        <= DEFAULT_SEED;
            ref_seed    <= DEFAULT_SEED;
            rr_ptr      <= '0;
            adv_cnt     <= '0;
            gnt         <= '0;
            rnd_valid   <= 1'b0;
            rnd_data    <= '0;
            rnd_id      <= '0;
            period_done <= 1'b0;
            period_cnt  <= '0;
            busy        <= 1'b0;
        end else begin
            gnt         <= '0;
            rnd_valid   <= 1'b0;
            period_done <= 1'b0;
            busy        <= 1'b0;

            if (seed_load) begin
                state    <= LOAD;
                busy     <= 1'b1;
                lfsr     <= seed_clean;
                ref_seed <= seed_clean;
                adv_cnt  <= '0;
            end else begin
                case (state)
                    IDLE:    if (enable) state <= RUN;
                    LOAD:    state <= RUN;
                    RUN:     state <= RUN;
                    default: state <= IDLE;
                endcase
            end

            if (grant_go) begin
                gnt       <= win_onehot;
                rnd_valid <= 1'b1;
                rnd_data  <= lfsr;
                rnd_id    <= win_idx;
                rr_ptr    <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
            end

            if (advance) begin
                lfsr <= nxt;
                if (nxt == ref_seed) begin
                    period_done <= 1'b1;
                    period_cnt  <= (adv_cnt == CNT_MAX) ? CNT_MAX : adv_cnt + (WIDTH+1)'(1);
                    adv_cnt     <= '0;
                end else if (adv_cnt != CNT_MAX) begin
                    adv_cnt <= adv_cnt + (WIDTH+1)'(1);
                end
            end
        end
    end

endmodule
